// File: rtl/data_ram_sized_if.sv
// Request/response bundle for the sized data RAM: the CPU MEM stage is the
// master, the RAM is the slave.
interface data_ram_sized_if #(
    parameter int ADDR_W = 32
);
    logic              Enable;
    logic              ReadWrite;
    logic [1:0]        Size;
    logic              SignExt;
    logic [ADDR_W-1:0] Address;
    logic [31:0]       DataIn;
    logic [31:0]       DataOut;
    logic              Ready;
    logic              Busy;
    logic              Error;

    modport master (
        output Enable, ReadWrite, Size, SignExt, Address, DataIn,
        input  DataOut, Ready, Busy, Error
    );

    modport slave (
        input  Enable, ReadWrite, Size, SignExt, Address, DataIn,
        output DataOut, Ready, Busy, Error
    );
endinterface

// File: rtl/data_ram_sized.sv
// Byte-array data memory with big-endian byte/half/word/doubleword access,
// registered request/ready handshake and configurable wait states.
// Misaligned or out-of-range requests are rejected with an Error pulse.
module data_ram_sized #(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic            clk,
    input  logic            reset,
    data_ram_sized_if.slave bus
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

    logic [7:0] Mem [0:DEPTH-1];

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              rw_q, sx_q, beat_q;
    logic [31:0]       din_q;
    logic [3:0]        cnt_q;
    logic [31:0]       dout_q;
    logic              rdy_q, busy_q, err_q;

    logic              misaligned, out_of_range, accept, reject, last_beat;
    logic [ADDR_W:0]   span, last_addr;
    logic [IW-1:0]     ba;
    logic [7:0]        b0, b1, b2, b3;
    logic [31:0]       rd_data;

    assign bus.DataOut = dout_q;
    assign bus.Ready   = rdy_q;
    assign bus.Busy    = busy_q;
    assign bus.Error   = err_q;

    // Request legality: alignment and final-byte range on the full address.
    always_comb begin
        misaligned = (bus.Size == 2'b01 && bus.Address[0]) ||
                     (bus.Size[1] && bus.Address[1:0] != 2'b00);
        case (bus.Size)
            2'b00:   span = '0;
            2'b01:   span = (ADDR_W+1)'(1);
            2'b10:   span = (ADDR_W+1)'(3);
            default: span = (ADDR_W+1)'(7);
        endcase
        last_addr    = {1'b0, bus.Address} + span;
        out_of_range = last_addr >= (ADDR_W+1)'(DEPTH);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic; a doubleword runs the WAIT/ACCESS pair twice.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (accept) state_nx = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
            S_WAIT:   if (cnt_q == 4'd1) state_nx = S_ACCESS;
            S_ACCESS: if (last_beat) state_nx = S_IDLE;
                      else state_nx = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Control decode: accept/reject in IDLE, final-beat detection.
    always_comb begin
        accept    = (state == S_IDLE) && bus.Enable && !misaligned && !out_of_range;
        reject    = (state == S_IDLE) && bus.Enable && (misaligned || out_of_range);
        last_beat = (size_q != 2'b11) || beat_q;
    end

    // Big-endian read assembly with optional sign extension for byte/half.
    always_comb begin
        ba = addr_q[IW-1:0];
        b0 = Mem[ba];
        b1 = Mem[ba + IW'(1)];
        b2 = Mem[ba + IW'(2)];
        b3 = Mem[ba + IW'(3)];
        case (size_q)
            2'b00:   rd_data = {{24{sx_q & b0[7]}}, b0};
            2'b01:   rd_data = {{16{sx_q & b0[7]}}, b0, b1};
            default: rd_data = {b0, b1, b2, b3};
        endcase
    end

    // Request latch, wait counter, beat sequencing and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            size_q <= '0;
            rw_q   <= 1'b0;
            sx_q   <= 1'b0;
            din_q  <= '0;
            beat_q <= 1'b0;
            cnt_q  <= '0;
            dout_q <= '0;
            rdy_q  <= 1'b0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            err_q <= reject;
            if (accept) begin
                addr_q <= bus.Address;
                size_q <= bus.Size;
                rw_q   <= bus.ReadWrite;
                sx_q   <= bus.SignExt;
                din_q  <= bus.DataIn;
                beat_q <= 1'b0;
                cnt_q  <= 4'(WAIT_STATES);
                busy_q <= 1'b1;
            end
            if (state == S_WAIT) cnt_q <= cnt_q - 4'd1;
            if (state == S_ACCESS) begin
                rdy_q <= 1'b1;
                if (rw_q) dout_q <= rd_data;
                if (last_beat) begin
                    busy_q <= 1'b0;
                end else begin
                    beat_q <= 1'b1;
                    addr_q <= addr_q + ADDR_W'(4);
                    din_q  <= bus.DataIn;
                    cnt_q  <= 4'(WAIT_STATES);
                end
            end
        end
    end

    // Byte commits; not reset so contents survive, and gated so a reset
    // edge never commits a pending write.
    always_ff @(posedge clk) begin
        if (!reset && state == S_ACCESS && !rw_q) begin
            case (size_q)
                2'b00: Mem[ba] <= din_q[7:0];
                2'b01: begin
                    Mem[ba]          <= din_q[15:8];
                    Mem[ba + IW'(1)] <= din_q[7:0];
                end
                default: begin
                    Mem[ba]          <= din_q[31:24];
                    Mem[ba + IW'(1)] <= din_q[23:16];
                    Mem[ba + IW'(2)] <= din_q[15:8];
                    Mem[ba + IW'(3)] <= din_q[7:0];
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_ram_sized.sv
// Bench for data_ram_sized: two instances (0 and 3 wait states) checked
// against a byte-array reference model, directed cases then random traffic.
module tb_data_ram_sized;
    localparam int DEPTH = 256;

    typedef struct packed {
        logic [31:0] dout;
        logic        rdy;
        logic        busy;
        logic        err;
    } rsp_t;

    logic clk, reset;
    int   nchk, nerr;
    logic [7:0]  model [2][DEPTH];
    logic [31:0] expd [2];
    logic [31:0] last;

    data_ram_sized_if #(.ADDR_W(32)) i0 ();
    data_ram_sized_if #(.ADDR_W(32)) i3 ();

    data_ram_sized #(.DEPTH(DEPTH), .ADDR_W(32), .WAIT_STATES(0))
        d0 (.clk(clk), .reset(reset), .bus(i0));
    data_ram_sized #(.DEPTH(DEPTH), .ADDR_W(32), .WAIT_STATES(3))
        d3 (.clk(clk), .reset(reset), .bus(i3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drv(input int s, input bit en, input bit rw, input logic [1:0] sz,
                       input bit sx, input logic [31:0] a, input logic [31:0] d);
        if (s == 1) begin
            i3.Enable = en; i3.ReadWrite = rw; i3.Size = sz;
            i3.SignExt = sx; i3.Address = a; i3.DataIn = d;
        end else begin
            i0.Enable = en; i0.ReadWrite = rw; i0.Size = sz;
            i0.SignExt = sx; i0.Address = a; i0.DataIn = d;
        end
    endtask

    function automatic rsp_t smp(input int s);
        rsp_t r;
        if (s == 1) r = '{i3.DataOut, i3.Ready, i3.Busy, i3.Error};
        else        r = '{i0.DataOut, i0.Ready, i0.Busy, i0.Error};
        return r;
    endfunction

    function automatic logic [31:0] hs(input rsp_t r);
        return 32'({r.rdy, r.busy, r.err});
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    // Reference rules: natural alignment (4 for doubleword), last byte < DEPTH.
    function automatic bit is_bad(input logic [1:0] sz, input logic [31:0] a);
        longint ua  = {32'd0, a};
        longint tot = (sz == 2'b11) ? 8 : nbytes(sz);
        longint al  = (sz == 2'b11) ? 4 : nbytes(sz);
        return (ua % al != 0) || (ua + tot - 1 >= DEPTH);
    endfunction

    function automatic logic [31:0] mread(input int s, input logic [31:0] a,
                                          input logic [1:0] sz, input bit sx);
        int n = nbytes(sz);
        logic [31:0] v = 0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(model[s][int'(a) + i]);
        if (sx && sz == 2'b00 && v >= 32'd128)   v = v + 32'hFFFFFF00;
        if (sx && sz == 2'b01 && v >= 32'd32768) v = v + 32'hFFFF0000;
        return v;
    endfunction

    task automatic mwrite(input int s, input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] d);
        int n = nbytes(sz);
        logic [31:0] sh;
        for (int i = 0; i < n; i++) begin
            sh = d >> (8 * (n - 1 - i));
            model[s][int'(a) + i] = sh[7:0];
        end
    endtask

    // One legal transaction, checking Ready/Busy on every cycle and DataOut per beat.
    task automatic do_op(input int s, input bit rw, input logic [1:0] sz, input bit sx,
                         input logic [31:0] a, input logic [31:0] dw0, input logic [31:0] dw1,
                         input bit poke, output logic [31:0] lst);
        int ws = (s == 1) ? 3 : 0;
        int nb = (sz == 2'b11) ? 2 : 1;
        int n  = nb * (ws + 1);
        int b  = 0;
        bit er, eb;
        rsp_t r;
        @(negedge clk); drv(s, 1'b1, rw, sz, sx, a, dw0);
        @(posedge clk); #1; r = smp(s);
        chk("accept", hs(r), 32'b010);
        @(negedge clk);
        if (poke) drv(s, 1'b1, 1'b0, 2'b10, 1'b0, 32'd40, dw1);
        else      drv(s, 1'b0, rw, sz, sx, a, dw1);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1; r = smp(s);
            er = (k % (ws + 1)) == 0;
            eb = k < n;
            chk("handshake", hs(r), 32'({er, eb, 1'b0}));
            if (er) begin
                if (rw) expd[s] = mread(s, a + 32'(4 * b), sz, sx);
                else    mwrite(s, a + 32'(4 * b), sz, (b == 1) ? dw1 : dw0);
                chk(rw ? "rdata" : "wr_dout_hold", r.dout, expd[s]);
                b++;
            end
            @(negedge clk); drv(s, 1'b0, rw, sz, sx, a, dw1);
        end
        lst = expd[s];
    endtask

    task automatic do_err(input int s, input bit rw, input logic [1:0] sz, input logic [31:0] a);
        rsp_t r;
        @(negedge clk); drv(s, 1'b1, rw, sz, 1'b0, a, 32'h5A5A5A5A);
        @(posedge clk); #1; r = smp(s);
        chk("err_pulse", hs(r), 32'b001);
        chk("err_dout", r.dout, expd[s]);
        @(negedge clk); drv(s, 1'b0, rw, sz, 1'b0, a, 32'h0);
        @(posedge clk); #1; r = smp(s);
        chk("err_clear", hs(r), 32'b000);
    endtask

    initial begin
        logic [7:0] tp [8];
        rsp_t r;
        int   bad, s;
        bit   rw, sx;
        logic [1:0]  sz;
        logic [31:0] a;
        tp = '{8'h80, 8'h12, 8'h34, 8'h56, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        nchk = 0; nerr = 0;
        drv(0, 0, 0, 2'b00, 0, 0, 0);
        drv(1, 0, 0, 2'b00, 0, 0, 0);
        reset = 1'b1;
        #12;
        for (int i = 0; i < 2; i++) begin
            r = smp(i);
            chk("reset_outs", 32'({r.rdy, r.busy, r.err}) | r.dout, 32'h0);
            expd[i] = 32'h0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            model[0][i] = (i < 8) ? tp[i] : 8'($urandom);
            model[1][i] = (i < 8) ? tp[i] : 8'($urandom);
            d0.Mem[i] = model[0][i];
            d3.Mem[i] = model[1][i];
        end
        @(negedge clk); reset = 1'b0;

        // Directed: extension, halfword write then word read, doubleword with waits.
        do_op(0, 1, 2'b00, 1, 32'd0, 0, 0, 0, last); chk("tp_byte_sx", last, 32'hFFFFFF80);
        do_op(0, 1, 2'b00, 0, 32'd0, 0, 0, 0, last); chk("tp_byte_zx", last, 32'h00000080);
        do_op(0, 0, 2'b01, 0, 32'd4, 32'h0000ABCD, 0, 0, last);
        do_op(0, 1, 2'b10, 0, 32'd4, 0, 0, 0, last); chk("tp_word_rd", last, 32'hABCDDEF0);
        do_op(1, 0, 2'b11, 0, 32'd8, 32'h11223344, 32'h55667788, 0, last);
        do_op(1, 1, 2'b11, 0, 32'd8, 0, 0, 0, last); chk("tp_dword_b1", last, 32'h55667788);
        do_op(1, 1, 2'b10, 0, 32'd8, 0, 0, 0, last); chk("tp_dword_b0", last, 32'h11223344);

        // Rejections: misaligned and final byte past the end.
        do_err(0, 1, 2'b10, 32'd2);
        do_err(0, 1, 2'b10, 32'(DEPTH - 2));
        do_err(1, 0, 2'b11, 32'(DEPTH - 4));
        do_err(1, 0, 2'b01, 32'h0001_0000);

        // Enable pulsed while busy: a write to 40 must not happen.
        do_op(1, 1, 2'b10, 0, 32'd44, 0, 32'hFFFFFFFF, 1, last);
        do_op(1, 1, 2'b10, 0, 32'd40, 0, 0, 0, last);

        // Reset during WAIT of a word write: no commit, outputs cleared.
        @(negedge clk); drv(1, 1, 0, 2'b10, 0, 32'd16, 32'hDEADBEEF);
        @(posedge clk); #1;
        @(negedge clk); drv(1, 0, 0, 2'b10, 0, 32'd16, 32'hDEADBEEF);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            r = smp(i);
            chk("midreset_outs", 32'({r.rdy, r.busy, r.err}) | r.dout, 32'h0);
            expd[i] = 32'h0;
        end
        @(posedge clk); @(negedge clk); reset = 1'b0;
        do_op(1, 1, 2'b10, 0, 32'd16, 0, 0, 0, last);
        chk("midreset_nocommit", last, {model[1][16], model[1][17], model[1][18], model[1][19]});

        // Random traffic on both instances.
        for (int i = 0; i < 120; i++) begin
            s  = int'($urandom_range(0, 1));
            rw = 1'($urandom);
            sx = 1'($urandom);
            sz = 2'($urandom);
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1, 2:    a = $urandom_range(0, DEPTH + 8);
                default: a = 32'($urandom_range(0, DEPTH / 4) * 4);
            endcase
            if (is_bad(sz, a)) do_err(s, rw, sz, a);
            else do_op(s, rw, sz, sx, a, $urandom, $urandom, 0, last);
        end

        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (d0.Mem[i] !== model[0][i]) bad++;
        chk("mem_final_ws0", 32'(bad), 32'd0);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (d3.Mem[i] !== model[1][i]) bad++;
        chk("mem_final_ws3", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
